// File: rtl/mtr_drv_pkg.sv
// Shared types, defaults and the duty slew helper for the multi-channel motor driver.
// Optional feature macro: MTR_DRV_SLEW_EN (rate-limited duty updates).
package mtr_drv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        REV  = 2'd2,
        DEAD = 2'd3
    } ch_state_t;

    localparam int DEF_NUM_CH    = 2;
    localparam int DEF_SPD_W     = 11;
    localparam int DEF_DEAD_CYC  = 64;
    localparam int DEF_SLEW_STEP = 16;

    // Move cur toward tgt by at most step, landing exactly on tgt when close enough.
    function automatic int unsigned slew_duty(input int unsigned cur,
                                              input int unsigned tgt,
                                              input int unsigned step);
        if (tgt > cur)
            return ((tgt - cur) > step) ? (cur + step) : tgt;
        else
            return ((cur - tgt) > step) ? (cur - step) : tgt;
    endfunction

endpackage

// File: rtl/mtr_pwm_ch.sv
// One H-bridge channel: direction state machine with dead time on reversal,
// duty latched at the period boundary, registered forward/reverse PWM outputs.
// Optional feature macro: MTR_DRV_SLEW_EN (duty ramps by SLEW_STEP per period).
module mtr_pwm_ch
    import mtr_drv_pkg::*;
#(
    parameter int SPD_W    = DEF_SPD_W,
    parameter int DEAD_CYC = DEF_DEAD_CYC
`ifdef MTR_DRV_SLEW_EN
    , parameter int SLEW_STEP = DEF_SLEW_STEP
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [SPD_W-1:0] cnt,
    input  logic             cnt_max,
    input  logic [SPD_W-1:0] spd,
    input  logic             rev,
    output logic             PWM_frwrd,
    output logic             PWM_rev,
    output logic             dead
);

    localparam int DC_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

    ch_state_t         state;
    logic [SPD_W-1:0]  duty_q;
    logic [SPD_W-1:0]  duty_nxt;
    logic [DC_W-1:0]   dead_cnt;
    logic              tgt_rev;

    // Duty value adopted at the next boundary (direct load, or one slew step).
    always_comb begin
`ifdef MTR_DRV_SLEW_EN
        duty_nxt = SPD_W'(slew_duty(32'(duty_q), 32'(spd), SLEW_STEP));
`else
        duty_nxt = spd;
`endif
    end

    // Direction state machine, dead-time countdown, duty latch and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            duty_q    <= '0;
            dead_cnt  <= '0;
            tgt_rev   <= 1'b0;
            PWM_frwrd <= 1'b0;
            PWM_rev   <= 1'b0;
            dead      <= 1'b0;
        end else begin
            PWM_frwrd <= en && (state == FWD) && (cnt < duty_q);
            PWM_rev   <= en && (state == REV) && (cnt < duty_q);
            dead      <= (state == DEAD);

            if (cnt_max) begin
                duty_q <= duty_nxt;
            end

            if (cnt_max && !en) begin
                state <= IDLE;
            end else if (state == DEAD) begin
                if (dead_cnt == '0) begin
                    state <= tgt_rev ? REV : FWD;
                end else begin
                    dead_cnt <= dead_cnt - 1'b1;
                end
            end else if (cnt_max) begin
                case (state)
                    IDLE: state <= rev ? REV : FWD;
                    FWD: begin
                        if (rev) begin
                            if (DEAD_CYC == 0) begin
                                state <= REV;
                            end else begin
                                state    <= DEAD;
                                dead_cnt <= DC_W'(DEAD_CYC - 1);
                                tgt_rev  <= 1'b1;
`ifdef MTR_DRV_SLEW_EN
                                duty_q   <= '0;
`endif
                            end
                        end
                    end
                    REV: begin
                        if (!rev) begin
                            if (DEAD_CYC == 0) begin
                                state <= FWD;
                            end else begin
                                state    <= DEAD;
                                dead_cnt <= DC_W'(DEAD_CYC - 1);
                                tgt_rev  <= 1'b0;
`ifdef MTR_DRV_SLEW_EN
                                duty_q   <= '0;
`endif
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/mtr_drv_multi.sv
// Multi-channel motor driver: one shared free-running PWM counter feeding
// NUM_CH independent H-bridge channels.
// Optional feature macro: MTR_DRV_SLEW_EN (duty slew limiting in every channel).
module mtr_drv_multi
    import mtr_drv_pkg::*;
#(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int SPD_W    = DEF_SPD_W,
    parameter int DEAD_CYC = DEF_DEAD_CYC
`ifdef MTR_DRV_SLEW_EN
    , parameter int SLEW_STEP = DEF_SLEW_STEP
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [NUM_CH*SPD_W-1:0] spd,
    input  logic [NUM_CH-1:0]       rev,
    output logic [NUM_CH-1:0]       PWM_frwrd,
    output logic [NUM_CH-1:0]       PWM_rev,
    output logic [NUM_CH-1:0]       dead,
    output logic                    prd_strt
);

    logic [SPD_W-1:0] cnt;
    logic             cnt_max;

    // Free-running period counter, wraps naturally at 2**SPD_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign cnt_max  = &cnt;
    assign prd_strt = (cnt == '0);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        mtr_pwm_ch #(
            .SPD_W    (SPD_W),
            .DEAD_CYC (DEAD_CYC)
`ifdef MTR_DRV_SLEW_EN
            , .SLEW_STEP(SLEW_STEP)
`endif
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .cnt       (cnt),
            .cnt_max   (cnt_max),
            .spd       (spd[i*SPD_W +: SPD_W]),
            .rev       (rev[i]),
            .PWM_frwrd (PWM_frwrd[i]),
            .PWM_rev   (PWM_rev[i]),
            .dead      (dead[i])
        );
    end

endmodule
